// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Bus bundle around the MEM stage. Carries the EX->MEM
//                valid/allow_in handshake and payload, the data-SRAM read
//                data, the MEM->WB handshake and register-file write fields,
//                and the decode-stage forwarding port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
  parameter int XLEN = 32
);
  // EX -> MEM
  logic            to_mem_valid;
  logic            mem_allow_in;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_res;
  logic [2:0]      ex_ld_op;
  logic [3:0]      ex_rf_we;
  logic [4:0]      ex_rf_waddr;

  // Data SRAM read return
  logic [XLEN-1:0] data_sram_rdata;

  // MEM -> WB
  logic            wb_allow_in;
  logic            to_wb_valid;
  logic [XLEN-1:0] mem_pc;
  logic [3:0]      mem_rf_we;
  logic [4:0]      mem_rf_waddr;
  logic [XLEN-1:0] mem_rf_wdata;

  // Decode-stage bypass
  logic            fwd_valid;
  logic [4:0]      fwd_waddr;
  logic [XLEN-1:0] fwd_wdata;

  // Surrounding pipeline (EX, SRAM, WB, decode) drives the stage
  modport master (
    output to_mem_valid, ex_pc, ex_res, ex_ld_op, ex_rf_we, ex_rf_waddr,
    output data_sram_rdata, wb_allow_in,
    input  mem_allow_in, to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr,
    input  mem_rf_wdata, fwd_valid, fwd_waddr, fwd_wdata
  );

  // The MEM stage itself
  modport slave (
    input  to_mem_valid, ex_pc, ex_res, ex_ld_op, ex_rf_we, ex_rf_waddr,
    input  data_sram_rdata, wb_allow_in,
    output mem_allow_in, to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr,
    output mem_rf_wdata, fwd_valid, fwd_waddr, fwd_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of the five-stage pipeline. Accepts instructions
//                from EX, receives synchronous data-SRAM read data one cycle
//                after acceptance, aligns/extends load data and hands the
//                register-file write fields to WB. Optionally captures the
//                SRAM read data when WB stalls so the result survives the
//                SRAM output changing. Drives a forwarding port for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int XLEN       = 32,   // only 32 is supported
  parameter bit HOLD_RDATA = 1'b1  // 1: capture rdata under WB stall
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  // Load opcode encoding; 0, 6 and 7 are non-loads
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_W  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  // --------------------------------------------------------------------------
  // Stage state
  // --------------------------------------------------------------------------
  logic            mem_valid_q, mem_valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] res_q,       res_d;
  logic [2:0]      ld_op_q,     ld_op_d;
  logic [3:0]      rf_we_q,     rf_we_d;
  logic [4:0]      rf_waddr_q,  rf_waddr_d;

  logic            mem_ready_go;
  logic            mem_allow_in;
  logic            accept;

  logic [XLEN-1:0] load_src;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] result;

  // Single-cycle stage: the instruction is always ready to leave
  assign mem_ready_go = 1'b1;
  assign mem_allow_in = !mem_valid_q || (mem_ready_go && bus.wb_allow_in);
  assign accept       = bus.to_mem_valid && mem_allow_in;

  // Next-state for occupancy and payload: refill when allowed, else hold
  always_comb begin
    mem_valid_d = mem_valid_q;
    pc_d        = pc_q;
    res_d       = res_q;
    ld_op_d     = ld_op_q;
    rf_we_d     = rf_we_q;
    rf_waddr_d  = rf_waddr_q;
    if (mem_allow_in) begin
      mem_valid_d = bus.to_mem_valid;
    end
    if (accept) begin
      pc_d       = bus.ex_pc;
      res_d      = bus.ex_res;
      ld_op_d    = bus.ex_ld_op;
      rf_we_d    = bus.ex_rf_we;
      rf_waddr_d = bus.ex_rf_waddr;
    end
  end

  // Occupancy and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      pc_q        <= '0;
      res_q       <= '0;
      ld_op_q     <= '0;
      rf_we_q     <= '0;
      rf_waddr_q  <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      pc_q        <= pc_d;
      res_q       <= res_d;
      ld_op_q     <= ld_op_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read-data capture. The SRAM presents the word only in the cycle after
  // acceptance; if WB refuses it that cycle, the word is latched so later
  // SRAM traffic cannot corrupt the pending load result.
  // --------------------------------------------------------------------------
  generate
    if (HOLD_RDATA) begin : g_hold
      logic            rdata_fresh_q;
      logic            hold_valid_q, hold_valid_d;
      logic [XLEN-1:0] hold_data_q,  hold_data_d;

      // Capture on a stalled fresh cycle; a new acceptance retires the copy
      always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (accept) begin
          hold_valid_d = 1'b0;
        end else if (rdata_fresh_q && !bus.wb_allow_in && mem_valid_q) begin
          hold_valid_d = 1'b1;
          hold_data_d  = bus.data_sram_rdata;
        end
      end

      // Fresh flag marks the single cycle the SRAM output belongs to us
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_fresh_q <= 1'b0;
          hold_valid_q  <= 1'b0;
          hold_data_q   <= '0;
        end else begin
          rdata_fresh_q <= accept;
          hold_valid_q  <= hold_valid_d;
          hold_data_q   <= hold_data_d;
        end
      end

      assign load_src = hold_valid_q ? hold_data_q : bus.data_sram_rdata;
    end else begin : g_no_hold
      // WB never stalls in this configuration, so the live word is enough
      assign load_src = bus.data_sram_rdata;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Load alignment and extension. Misaligned halfword addresses are faulted
  // upstream, so res[0] is simply ignored for halfword loads.
  // --------------------------------------------------------------------------

  // Pick the addressed byte and halfword out of the source word
  always_comb begin
    byte_sel = load_src[7:0];
    case (res_q[1:0])
      2'd0:    byte_sel = load_src[7:0];
      2'd1:    byte_sel = load_src[15:8];
      2'd2:    byte_sel = load_src[23:16];
      default: byte_sel = load_src[31:24];
    endcase
    half_sel = res_q[1] ? load_src[31:16] : load_src[15:0];
  end

  // Extend per opcode; non-loads pass the ALU result through
  always_comb begin
    result = res_q;
    case (ld_op_q)
      LD_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
      LD_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
      LD_W:    result = load_src;
      default: result = res_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mem_allow_in = mem_allow_in;
  assign bus.to_wb_valid  = mem_valid_q && mem_ready_go;
  assign bus.mem_pc       = pc_q;
  assign bus.mem_rf_we    = mem_valid_q ? rf_we_q : 4'b0000;
  assign bus.mem_rf_waddr = rf_waddr_q;
  assign bus.mem_rf_wdata = result;

  // r0 is hard-wired zero, so a write to it must never be bypassed
  assign bus.fwd_valid    = mem_valid_q && (|rf_we_q) && (rf_waddr_q != 5'd0);
  assign bus.fwd_waddr    = rf_waddr_q;
  assign bus.fwd_wdata    = result;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage with a transaction-level
//                reference model (stage occupancy + result computed from an
//                SRAM image at acceptance time).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   rst_next = 1'b1;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) bus ();

  mem_stage #(.XLEN(32), .HOLD_RDATA(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sram [16];

  // Reference model state
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_wdata;
  logic [3:0]  m_we;
  logic [4:0]  m_waddr;
  bit          m_fresh;
  logic [31:0] m_last_addr;
  int          transfers;

  // Architectural result of an instruction given its opcode, address and word
  function automatic logic [31:0] load_result(input logic [2:0] op,
                                              input logic [31:0] addr,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> (8 * addr[1:0]));
    h = 16'(word >> (16 * addr[1]));
    case (op)
      3'd1:    return 32'($signed(b));
      3'd2:    return 32'($signed(h));
      3'd3:    return word;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return addr;
    endcase
  endfunction

  // Apply one cycle of stimulus at the falling edge; SRAM returns the word
  // for last cycle's acceptance, otherwise unrelated noise
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] res,
                       input logic [2:0] op, input logic [3:0] we,
                       input logic [4:0] wa, input bit wba);
    @(negedge clk);
    reset               = rst_next;
    bus.to_mem_valid    = v;
    bus.ex_pc           = pc;
    bus.ex_res          = res;
    bus.ex_ld_op        = op;
    bus.ex_rf_we        = we;
    bus.ex_rf_waddr     = wa;
    bus.wb_allow_in     = wba;
    bus.data_sram_rdata = m_fresh ? sram[m_last_addr[5:2]] : $urandom;
    #1;
  endtask

  // Advance the model across the rising edge
  task automatic tick();
    bit allow;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_fresh = 1'b0;
    end else begin
      allow = !m_valid || bus.wb_allow_in;
      if (m_valid && bus.wb_allow_in) transfers++;
      m_fresh = bus.to_mem_valid && allow;
      if (m_fresh) begin
        m_pc        = bus.ex_pc;
        m_we        = bus.ex_rf_we;
        m_waddr     = bus.ex_rf_waddr;
        m_wdata     = load_result(bus.ex_ld_op, bus.ex_res, sram[bus.ex_res[5:2]]);
        m_last_addr = bus.ex_res;
      end
      if (allow) m_valid = bus.to_mem_valid;
    end
  endtask

  task automatic test_reset();
    rst_next = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 32'h100, 32'h55, 3'd3, 4'hF, 5'd3, 0); tick();
    rst_next = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_to_wb_valid got %b exp 0", bus.to_wb_valid); end
    n_checks++; if (bus.mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL reset_allow_in got %b exp 1", bus.mem_allow_in); end
    n_checks++; if (bus.mem_rf_we !== 4'h0) begin n_fail++; $display("FAIL reset_rf_we got %h exp 0", bus.mem_rf_we); end
    n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %b exp 0", bus.fwd_valid); end
    n_checks++; if (bus.mem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", bus.mem_pc); end
    tick();
    // Empty stage with no input stays empty
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_to_wb_valid got %b exp 0", bus.to_wb_valid); end
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] exp_w [3];
    int t0;
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
    t0 = transfers;
    drive(1, 32'h200, 32'h11, 3'd0, 4'hF, 5'd1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1, 32'h204 + 32'(4 * i), exp_w[i + 1], 3'd0, 4'hF, 5'd1, 1);
      else       drive(0, 0, 0, 0, 0, 0, 1);
      n_checks++; if (bus.to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.to_wb_valid); end
      n_checks++; if (bus.mem_rf_wdata !== exp_w[i]) begin n_fail++; $display("FAIL stream_wdata[%0d] got %h exp %h", i, bus.mem_rf_wdata, exp_w[i]); end
      n_checks++; if (bus.mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL stream_allow[%0d] got %b exp 1", i, bus.mem_allow_in); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", bus.to_wb_valid); end
    n_checks++; if (transfers - t0 !== 3) begin n_fail++; $display("FAIL stream_count got %0d exp 3", transfers - t0); end
    tick();
  endtask

  task automatic test_load_decode();
    logic [2:0]  ops [5];
    logic [31:0] exp_w [5];
    sram[8] = 32'h80FF7F01;
    ops[0] = 3'd1; exp_w[0] = 32'hFFFFFFFF;
    ops[1] = 3'd4; exp_w[1] = 32'h000000FF;
    ops[2] = 3'd2; exp_w[2] = 32'hFFFF80FF;
    ops[3] = 3'd5; exp_w[3] = 32'h000080FF;
    ops[4] = 3'd3; exp_w[4] = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h300, 32'h22, ops[i], 4'hF, 5'd9, 1); tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      n_checks++; if (bus.mem_rf_wdata !== exp_w[i]) begin n_fail++; $display("FAIL load_op%0d got %h exp %h", ops[i], bus.mem_rf_wdata, exp_w[i]); end
      tick();
    end
  endtask

  task automatic test_stall();
    int t0;
    sram[4] = 32'hDEADBEEF;
    drive(1, 32'h400, 32'h10, 3'd3, 4'hF, 5'd7, 1); tick();
    t0 = transfers;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h404, 32'h99, 3'd0, 4'hF, 5'd8, 0);
      n_checks++; if (bus.mem_rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_wdata[%0d] got %h exp deadbeef", i, bus.mem_rf_wdata); end
      n_checks++; if (bus.mem_allow_in !== 1'b0) begin n_fail++; $display("FAIL stall_allow[%0d] got %b exp 0", i, bus.mem_allow_in); end
      n_checks++; if (bus.to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, bus.to_wb_valid); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.mem_rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL release_wdata got %h exp deadbeef", bus.mem_rf_wdata); end
    n_checks++; if (bus.mem_pc !== 32'h400) begin n_fail++; $display("FAIL release_pc got %h exp 400", bus.mem_pc); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (transfers - t0 !== 1) begin n_fail++; $display("FAIL release_count got %0d exp 1", transfers - t0); end
    n_checks++; if (bus.to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL release_empty got %b exp 0", bus.to_wb_valid); end
    tick();
  endtask

  task automatic test_forwarding();
    drive(1, 32'h500, 32'h1234, 3'd0, 4'hF, 5'd0, 1); tick();
    drive(1, 32'h504, 32'h5678, 3'd0, 4'hF, 5'd5, 1);
    n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_r0 got %b exp 0", bus.fwd_valid); end
    n_checks++; if (bus.mem_rf_we !== 4'hF) begin n_fail++; $display("FAIL fwd_r0_we got %h exp f", bus.mem_rf_we); end
    tick();
    drive(1, 32'h508, 32'h9ABC, 3'd0, 4'h0, 5'd7, 1);
    n_checks++; if (bus.fwd_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_r5_valid got %b exp 1", bus.fwd_valid); end
    n_checks++; if (bus.fwd_waddr !== 5'd5) begin n_fail++; $display("FAIL fwd_r5_waddr got %0d exp 5", bus.fwd_waddr); end
    n_checks++; if (bus.fwd_wdata !== 32'h5678) begin n_fail++; $display("FAIL fwd_r5_wdata got %h exp 5678", bus.fwd_wdata); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_we0 got %b exp 0", bus.fwd_valid); end
    tick();
  endtask

  task automatic test_reset_stall();
    sram[12] = 32'hCAFEF00D;
    sram[13] = 32'h01234567;
    drive(1, 32'h600, 32'h30, 3'd3, 4'hF, 5'd4, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    rst_next = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    rst_next = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rststall_valid got %b exp 0", bus.to_wb_valid); end
    n_checks++; if (bus.mem_allow_in !== 1'b1) begin n_fail++; $display("FAIL rststall_allow got %b exp 1", bus.mem_allow_in); end
    n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rststall_fwd got %b exp 0", bus.fwd_valid); end
    tick();
    drive(1, 32'h604, 32'h34, 3'd3, 4'hF, 5'd4, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (bus.mem_rf_wdata !== 32'h01234567) begin n_fail++; $display("FAIL rststall_newload got %h exp 01234567", bus.mem_rf_wdata); end
    tick();
  endtask

  // Random traffic with back-to-back acceptance and random WB back-pressure
  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      drive(r[0] | r[1], $urandom, $urandom, 3'($urandom_range(0, 7)),
            4'($urandom), 5'($urandom), ($urandom_range(0, 9) < 7));
      n_checks++; if (bus.to_wb_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bus.to_wb_valid, m_valid); end
      n_checks++; if (bus.mem_allow_in !== (!m_valid || bus.wb_allow_in)) begin n_fail++; $display("FAIL rnd_allow cyc %0d got %b exp %b", c, bus.mem_allow_in, !m_valid || bus.wb_allow_in); end
      if (m_valid) begin
        n_checks++; if (bus.mem_rf_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", c, bus.mem_rf_wdata, m_wdata); end
        n_checks++; if (bus.mem_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h exp %h", c, bus.mem_pc, m_pc); end
        n_checks++; if (bus.mem_rf_we !== m_we) begin n_fail++; $display("FAIL rnd_we cyc %0d got %h exp %h", c, bus.mem_rf_we, m_we); end
        n_checks++; if (bus.mem_rf_waddr !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr cyc %0d got %0d exp %0d", c, bus.mem_rf_waddr, m_waddr); end
        n_checks++; if (bus.fwd_valid !== ((m_we != 4'h0) && (m_waddr != 5'd0))) begin n_fail++; $display("FAIL rnd_fwd cyc %0d got %b", c, bus.fwd_valid); end
        n_checks++; if (bus.fwd_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_fwd_wdata cyc %0d got %h exp %h", c, bus.fwd_wdata, m_wdata); end
      end else begin
        n_checks++; if (bus.mem_rf_we !== 4'h0) begin n_fail++; $display("FAIL rnd_idle_we cyc %0d got %h exp 0", c, bus.mem_rf_we); end
        n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_fwd cyc %0d got %b exp 0", c, bus.fwd_valid); end
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = $urandom;
    m_valid = 1'b0; m_fresh = 1'b0; transfers = 0;
    m_pc = '0; m_wdata = '0; m_we = '0; m_waddr = '0; m_last_addr = '0;
    bus.to_mem_valid = 1'b0; bus.ex_pc = '0; bus.ex_res = '0; bus.ex_ld_op = '0;
    bus.ex_rf_we = '0; bus.ex_rf_waddr = '0; bus.wb_allow_in = 1'b1;
    bus.data_sram_rdata = '0;

    test_reset();
    test_streaming();
    test_load_decode();
    test_stall();
    test_forwarding();
    test_reset_stall();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
